// File: rtl/crypto_pkg.sv
// Shared register-bank geometry and arbitration state encoding for the crypto datapath.
package crypto_pkg;

  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned REG_DATA_W = 16;
  localparam int unsigned NUM_REGS   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first eligible requester at or after pointer wins.
module rr_arbiter #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [PTR_W-1:0] pointer,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             any_gnt
);

  logic [N_REQ-1:0] eligible;
  int unsigned      idx;

  always_comb begin
    eligible = req & mask;
    gnt      = '0;
    gnt_idx  = '0;
    any_gnt  = 1'b0;
    idx      = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = 32'(pointer) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any_gnt && eligible[PTR_W'(idx)]) begin
        any_gnt = 1'b1;
        gnt_idx = PTR_W'(idx);
      end
    end
    if (any_gnt) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Shares the single-port 8x16 register bank among N_REQ requesters with round-robin
// grant, bounded lock for bursts, and a 1-cycle tagged read-response path.
module reg_bank_arbiter
  import crypto_pkg::*;
#(
  parameter int unsigned N_REQ    = 3,
  parameter int unsigned ADDR_W   = REG_ADDR_W,
  parameter int unsigned DATA_W   = REG_DATA_W,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          we,
  input  logic [N_REQ*ADDR_W-1:0]   addr,
  input  logic [N_REQ*DATA_W-1:0]   wdata,
  input  logic [N_REQ-1:0]          lock,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic [ADDR_W-1:0]         bank_address_1,
  output logic [ADDR_W-1:0]         bank_address,
  output logic [DATA_W-1:0]         bank_data,
  output logic                      bank_rw,
  input  logic [DATA_W-1:0]         bank_rdata
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

  arb_state_t        state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0]  rd_valid_q, rd_valid_d;

  logic [N_REQ-1:0]  owner_bit;
  logic              owner_hold;
  logic              lock_expired;
  logic [N_REQ-1:0]  arb_mask;
  logic [N_REQ-1:0]  arb_gnt;
  logic [PTR_W-1:0]  arb_idx;
  logic              arb_any;

  logic              win_valid;
  logic [PTR_W-1:0]  win_idx;
  logic [N_REQ-1:0]  win_onehot;

  logic [ADDR_W-1:0] addr_a  [N_REQ];
  logic [DATA_W-1:0] wdata_a [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign addr_a[i]  = addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = wdata[i*DATA_W +: DATA_W];
  end

  assign owner_bit    = N_REQ'(1) << owner_q;
  assign owner_hold   = (state_q == LOCKED) && req[owner_q] && lock[owner_q];
  assign lock_expired = (cnt_q == CNT_W'(MAX_LOCK));

  // On forced release the owner sits out this round unless it is the only requester.
  assign arb_mask = (owner_hold && |(req & ~owner_bit)) ? ~owner_bit : '1;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req     (req),
    .mask    (arb_mask),
    .pointer (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any_gnt (arb_any)
  );

  // Ownership FSM, lock counter and round-robin pointer.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    win_valid  = 1'b0;
    win_idx    = owner_q;
    win_onehot = owner_bit;
    if (owner_hold && !lock_expired) begin
      win_valid = 1'b1;
      cnt_d     = cnt_q + CNT_W'(1);
    end else begin
      win_valid  = arb_any;
      win_idx    = arb_idx;
      win_onehot = arb_gnt;
      state_d    = arb_any ? GRANT : IDLE;
      cnt_d      = '0;
      if (arb_any) begin
        ptr_d = (arb_idx == PTR_W'(N_REQ - 1)) ? '0 : arb_idx + PTR_W'(1);
        if (lock[arb_idx] && !owner_hold) begin
          state_d = LOCKED;
          owner_d = arb_idx;
          cnt_d   = CNT_W'(1);
        end
      end
    end
  end

  // Grant and bank drive are combinational in the request cycle and forced idle in reset.
  always_comb begin
    gnt            = '0;
    bank_rw        = 1'b0;
    bank_address_1 = '0;
    bank_address   = '0;
    bank_data      = '0;
    rd_valid_d     = '0;
    if (rst_n && win_valid) begin
      gnt = win_onehot;
      if (we[win_idx]) begin
        bank_rw      = 1'b1;
        bank_address = addr_a[win_idx];
        bank_data    = wdata_a[win_idx];
      end else begin
        bank_address_1 = addr_a[win_idx];
        rd_valid_d     = win_onehot;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      rd_valid_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = bank_rdata;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter with a behavioural register bank and a read-response scoreboard.
module tb_reg_bank_arbiter;
  import crypto_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = REG_ADDR_W;
  localparam int unsigned DW = REG_DATA_W;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, we, lock;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt, rd_valid;
  logic [DW-1:0]   rd_data, bank_data, bank_rdata;
  logic [AW-1:0]   bank_address_1, bank_address;
  logic            bank_rw;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [N-1:0]  vld;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          sb_q[$];
  logic [DW-1:0] ref_mem [NUM_REGS];
  logic [DW-1:0] bank_mem [NUM_REGS];
  logic [DW-1:0] bank_q;

  always #5 clk = ~clk;

  reg_bank_arbiter #(
    .N_REQ    (N),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_LOCK (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .we             (we),
    .addr           (addr),
    .wdata          (wdata),
    .lock           (lock),
    .gnt            (gnt),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .bank_address_1 (bank_address_1),
    .bank_address   (bank_address),
    .bank_data      (bank_data),
    .bank_rw        (bank_rw),
    .bank_rdata     (bank_rdata)
  );

  // Single-port bank: one write or one registered read per clock.
  always @(posedge clk) begin
    if (bank_rw) bank_mem[bank_address] <= bank_data;
    else         bank_q <= bank_mem[bank_address_1];
  end
  assign bank_rdata = bank_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_req();
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
  endtask

  task automatic set_rq(input int i, input logic r, input logic w, input logic lk,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = r; we[i] = w; lock[i] = lk;
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
  endtask

  // One clock: check grant/bank drive mid-cycle, then the read response just after the edge.
  task automatic cycle(input logic [N-1:0] exp_g, input string tag);
    int            w;
    logic          e_we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    rsp_t          r;
    w = -1;
    for (int i = 0; i < N; i++) if (exp_g[i]) w = i;
    e_we = 1'b0; a = '0; d = '0;
    if (w >= 0) begin
      e_we = we[w];
      a    = addr[w*AW +: AW];
      d    = wdata[w*DW +: DW];
    end
    @(negedge clk);
    chk({tag, ".gnt"},     32'(gnt),            32'(exp_g));
    chk({tag, ".bank_rw"}, 32'(bank_rw),        32'(e_we));
    chk({tag, ".raddr"},   32'(bank_address_1), (e_we || w < 0) ? 32'd0 : 32'(a));
    chk({tag, ".waddr"},   32'(bank_address),   e_we ? 32'(a) : 32'd0);
    chk({tag, ".wdata"},   32'(bank_data),      e_we ? 32'(d) : 32'd0);
    if (w >= 0) begin
      if (e_we) ref_mem[a] = d;
      else begin
        r.vld  = exp_g;
        r.data = ref_mem[a];
        sb_q.push_back(r);
      end
    end
    @(posedge clk); #1;
    if (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(r.vld));
      chk({tag, ".rd_data"},  32'(rd_data),  32'(r.data));
    end else begin
      chk({tag, ".rd_valid"}, 32'(rd_valid), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      ref_mem[i]  = '0;
      bank_mem[i] = '0;
    end
    bank_q = '0;

    // Reset held with traffic present
    rst_n = 1'b0;
    clear_req();
    set_rq(0, 1'b1, 1'b1, 1'b0, 3'd2, 16'h1111);
    set_rq(1, 1'b1, 1'b0, 1'b0, 3'd4, 16'h0);
    #2;
    chk("rst.gnt",      32'(gnt),      32'd0);
    chk("rst.bank_rw",  32'(bank_rw),  32'd0);
    chk("rst.raddr",    32'(bank_address_1), 32'd0);
    chk("rst.rd_valid", 32'(rd_valid), 32'd0);
    @(posedge clk); #1;
    chk("rst.rd_valid_edge", 32'(rd_valid), 32'd0);
    chk("rst.waddr",    32'(bank_address), 32'd0);
    #2;
    clear_req();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Idle
    for (int i = 0; i < 4; i++) cycle(3'b000, "idle");

    // Write then read-back by another requester
    set_rq(0, 1'b1, 1'b1, 1'b0, 3'd5, 16'hA5A5);
    cycle(3'b001, "single.wr");
    clear_req();
    set_rq(1, 1'b1, 1'b0, 1'b0, 3'd5, 16'h0);
    cycle(3'b010, "single.rd");
    clear_req();
    cycle(3'b000, "single.rsp");

    // Bring pointer back to 0, then same-cycle write/read conflict on addr 3
    set_rq(2, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
    cycle(3'b100, "conf.pre");
    clear_req();
    set_rq(0, 1'b1, 1'b1, 1'b0, 3'd3, 16'h1234);
    set_rq(1, 1'b1, 1'b0, 1'b0, 3'd3, 16'h0);
    cycle(3'b001, "conf.wr");
    set_rq(0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    cycle(3'b010, "conf.rd");
    clear_req();
    cycle(3'b000, "conf.rsp");

    // Round-robin among three continuous readers
    set_rq(2, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
    cycle(3'b100, "rr.pre");
    set_rq(0, 1'b1, 1'b0, 1'b0, 3'd5, 16'h0);
    set_rq(1, 1'b1, 1'b0, 1'b0, 3'd3, 16'h0);
    for (int i = 0; i < 2; i++) begin
      cycle(3'b001, "rr.g0");
      cycle(3'b010, "rr.g1");
      cycle(3'b100, "rr.g2");
    end
    clear_req();
    cycle(3'b000, "rr.rsp");

    // Bounded lock: requester 2 holds for MAX_LOCK cycles, then 0 and 1 are served
    set_rq(2, 1'b1, 1'b0, 1'b1, 3'd3, 16'h0);
    cycle(3'b100, "lock.first");
    set_rq(0, 1'b1, 1'b0, 1'b0, 3'd5, 16'h0);
    set_rq(1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
    for (int i = 0; i < 7; i++) cycle(3'b100, "lock.hold");
    cycle(3'b001, "lock.rel0");
    cycle(3'b010, "lock.rel1");
    cycle(3'b100, "lock.relock");
    lock[2] = 1'b0;
    cycle(3'b001, "lock.drop");
    clear_req();
    cycle(3'b000, "lock.rsp");

    // Reset in the middle of a read response and a pending write
    set_rq(1, 1'b1, 1'b0, 1'b0, 3'd5, 16'h0);
    @(negedge clk);
    chk("mid.gnt", 32'(gnt), 32'b010);
    @(posedge clk); #1;
    chk("mid.rd_valid_pre", 32'(rd_valid), 32'b010);
    clear_req();
    set_rq(0, 1'b1, 1'b1, 1'b0, 3'd1, 16'hBEEF);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid.rd_valid", 32'(rd_valid), 32'd0);
    chk("mid.gnt_rst",  32'(gnt),      32'd0);
    chk("mid.bank_rw",  32'(bank_rw),  32'd0);
    chk("mid.wdata",    32'(bank_data), 32'd0);
    sb_q.delete();
    clear_req();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Pointer restarts at 0 after reset; dropped write must not have landed
    set_rq(0, 1'b1, 1'b0, 1'b0, 3'd1, 16'h0);
    set_rq(1, 1'b1, 1'b0, 1'b0, 3'd5, 16'h0);
    set_rq(2, 1'b1, 1'b0, 1'b0, 3'd3, 16'h0);
    cycle(3'b001, "post.g0");
    cycle(3'b010, "post.g1");
    clear_req();
    cycle(3'b000, "post.rsp");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
